// File: rtl/tc_sram_init_if.sv
// Request/response bundle of the tc_sram_init memory: one full read/write port per lane.
// Member names follow the memory's point of view; the requester uses the master modport.
interface tc_sram_init_if #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BeWidth   = 8
);
  logic [NumPorts-1:0]                 req_i;
  logic [NumPorts-1:0]                 we_i;
  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i;
  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i;
  logic [NumPorts-1:0][BeWidth-1:0]    be_i;
  logic [NumPorts-1:0]                 gnt_o;
  logic [NumPorts-1:0][DataWidth-1:0]  rdata_o;
  logic [NumPorts-1:0]                 rvalid_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rdata_o, rvalid_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/tc_sram_init.sv
// Multi-port behavioural SRAM with a pattern-fill engine and a fixed-latency read-valid pipeline.
// Grants are withheld while the fill runs, so fill writes and user writes never collide.
module tc_sram_init #(
  parameter int unsigned          NumWords    = 1024,
  parameter int unsigned          DataWidth   = 64,
  parameter int unsigned          ByteWidth   = 8,
  parameter int unsigned          NumPorts    = 2,
  parameter int unsigned          Latency     = 1,
  parameter string                RdwMode     = "read_first",
  parameter bit                   InitOnReset = 1'b1,
  parameter logic [DataWidth-1:0] InitPattern = '0,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          init_i,
  output logic          busy_o,
  tc_sram_init_if.slave bus
);

  localparam bit                   WriteFirst = (RdwMode == "write_first");
  localparam logic [AddrWidth:0]   WordsLim   = (AddrWidth + 1)'(NumWords);
  localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(NumWords - 1);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StInit = 1'b1
  } state_e;

  state_e                                    state_r;
  logic                                      busy_r;
  logic [AddrWidth-1:0]                      init_cnt_r;
  logic [DataWidth-1:0]                      mem_r [NumWords];
  logic [NumPorts-1:0]                       gnt_s;
  logic [NumPorts-1:0]                       wr_en_s;
  logic [NumPorts-1:0]                       rd_en_s;
  logic [NumPorts-1:0][DataWidth-1:0]        wmask_s;
  logic [NumPorts-1:0][DataWidth-1:0]        rd_word_s;
  logic [Latency-1:0][NumPorts-1:0]          vld_pipe_r;
  logic [Latency-1:0][NumPorts-1:0][DataWidth-1:0] dat_pipe_r;

  function automatic logic in_range(input logic [AddrWidth-1:0] addr);
    return ({1'b0, addr} < WordsLim);
  endfunction

  // The last byte lane may be narrower than ByteWidth when DataWidth is not a multiple of it.
  function automatic logic [DataWidth-1:0] be_mask(input logic [BeWidth-1:0] be);
    logic [DataWidth-1:0] mask;
    mask = '0;
    for (int k = 0; k < DataWidth; k++) begin
      mask[k] = be[k / ByteWidth];
    end
    return mask;
  endfunction

  assign gnt_s        = bus.req_i & {NumPorts{~busy_r}};
  assign bus.gnt_o    = gnt_s;
  assign busy_o       = busy_r;
  assign bus.rvalid_o = vld_pipe_r[Latency-1];
  assign bus.rdata_o  = dat_pipe_r[Latency-1];

  // Per-port write/read qualification and the word each granted read returns.
  always_comb begin
    wmask_s   = '0;
    wr_en_s   = '0;
    rd_en_s   = '0;
    rd_word_s = '0;
    for (int p = 0; p < NumPorts; p++) begin
      wmask_s[p] = be_mask(bus.be_i[p]);
      wr_en_s[p] = gnt_s[p] & bus.we_i[p] & in_range(bus.addr_i[p]);
      rd_en_s[p] = gnt_s[p] & ~bus.we_i[p];
    end
    // In write_first mode, same-address writes are folded in ascending port order so the
    // highest-index enabled port owns each byte, matching what lands in the array.
    for (int p = 0; p < NumPorts; p++) begin
      rd_word_s[p] = in_range(bus.addr_i[p]) ? mem_r[bus.addr_i[p]] : '0;
      for (int q = 0; q < NumPorts; q++) begin
        if (WriteFirst && wr_en_s[q] && (bus.addr_i[q] == bus.addr_i[p])) begin
          rd_word_s[p] = (rd_word_s[p] & ~wmask_s[q]) | (bus.wdata_i[q] & wmask_s[q]);
        end else begin
          rd_word_s[p] = rd_word_s[p];
        end
      end
    end
  end

  // Init sequencer: walks every word once, then returns to idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= InitOnReset ? StInit : StIdle;
      busy_r     <= InitOnReset;
      init_cnt_r <= '0;
    end else begin
      case (state_r)
        StIdle: begin
          busy_r     <= init_i;
          init_cnt_r <= '0;
          if (init_i) begin
            state_r <= StInit;
          end
        end
        StInit: begin
          if (init_cnt_r == LastAddr) begin
            state_r    <= StIdle;
            busy_r     <= 1'b0;
            init_cnt_r <= '0;
          end else begin
            init_cnt_r <= init_cnt_r + AddrWidth'(1);
          end
        end
        default: begin
          state_r    <= StIdle;
          busy_r     <= 1'b0;
          init_cnt_r <= '0;
        end
      endcase
    end
  end

  // Storage array; deliberately not reset so contents survive an aborted fill.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy_r) begin
        mem_r[init_cnt_r] <= InitPattern;
      end else begin
        for (int p = 0; p < NumPorts; p++) begin
          for (int k = 0; k < DataWidth; k++) begin
            if (wr_en_s[p] && wmask_s[p][k]) begin
              mem_r[bus.addr_i[p]][k] <= bus.wdata_i[p][k];
            end
          end
        end
      end
    end
  end

  // Read pipeline: data is captured at grant and only advances with its valid bit,
  // so the output stage holds its last value between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_r <= '0;
      dat_pipe_r <= '0;
    end else begin
      vld_pipe_r[0] <= rd_en_s;
      for (int p = 0; p < NumPorts; p++) begin
        if (rd_en_s[p]) begin
          dat_pipe_r[0][p] <= rd_word_s[p];
        end
      end
      for (int j = 1; j < Latency; j++) begin
        vld_pipe_r[j] <= vld_pipe_r[j-1];
        for (int p = 0; p < NumPorts; p++) begin
          if (vld_pipe_r[j-1][p]) begin
            dat_pipe_r[j][p] <= dat_pipe_r[j-1][p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tc_sram_init.sv
// Directed bench for tc_sram_init: one read_first and one write_first instance share stimulus.
// Expected values are hand-computed from the fill pattern and the write vectors below.
module tb_tc_sram_init;

  localparam logic [31:0] Pat = 32'hA5A5_A5A5;

  logic clk;
  logic rst;
  logic init;
  logic busy_rf;
  logic busy_wf;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  tc_sram_init_if #(.NumPorts(2), .AddrWidth(4), .DataWidth(32), .BeWidth(4)) bus_rf ();
  tc_sram_init_if #(.NumPorts(2), .AddrWidth(4), .DataWidth(32), .BeWidth(4)) bus_wf ();

  assign bus_wf.req_i   = bus_rf.req_i;
  assign bus_wf.we_i    = bus_rf.we_i;
  assign bus_wf.addr_i  = bus_rf.addr_i;
  assign bus_wf.wdata_i = bus_rf.wdata_i;
  assign bus_wf.be_i    = bus_rf.be_i;

  tc_sram_init #(
    .NumWords(16), .DataWidth(32), .ByteWidth(8), .NumPorts(2), .Latency(2),
    .RdwMode("read_first"), .InitOnReset(1'b1), .InitPattern(Pat)
  ) u_dut_rf (
    .clk_i(clk), .rst_i(rst), .init_i(init), .busy_o(busy_rf), .bus(bus_rf)
  );

  tc_sram_init #(
    .NumWords(16), .DataWidth(32), .ByteWidth(8), .NumPorts(2), .Latency(2),
    .RdwMode("write_first"), .InitOnReset(1'b1), .InitPattern(Pat)
  ) u_dut_wf (
    .clk_i(clk), .rst_i(rst), .init_i(init), .busy_o(busy_wf), .bus(bus_wf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  b0;
    logic [3:0]  b1;
    logic [1:0]  ev;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e1_wf;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1);
    bus_rf.req_i      = req;
    bus_rf.we_i       = we;
    bus_rf.addr_i[0]  = a0;
    bus_rf.addr_i[1]  = a1;
    bus_rf.wdata_i[0] = d0;
    bus_rf.wdata_i[1] = d1;
    bus_rf.be_i[0]    = b0;
    bus_rf.be_i[1]    = b1;
  endtask

  // Caller holds req_i=2'b11 so every busy cycle also proves the grant is withheld.
  task automatic count_busy(input string nm);
    int n = 0;
    while (busy_rf === 1'b1 && n < 40) begin
      chk($sformatf("%s_gnt%0d", nm, n), bus_rf.gnt_o, 2'b00);
      n++;
      @(negedge clk);
    end
    chk({nm, "_len"}, n, 16);
    chk({nm, "_wf_idle"}, busy_wf, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int it;
    vt[0] = '{req:2'b01, we:2'b01, a0:4'd3, a1:4'd0, d0:32'h1122_3344, d1:32'h0,
              b0:4'b0101, b1:4'b0000, ev:2'b00, e0:32'h0, e1:32'h0, e1_wf:32'h0};
    vt[1] = '{req:2'b11, we:2'b11, a0:4'd5, a1:4'd5, d0:32'h0000_00FF, d1:32'hFFFF_FF00,
              b0:4'b0011, b1:4'b0110, ev:2'b00, e0:32'h0, e1:32'h0, e1_wf:32'h0};
    vt[2] = '{req:2'b11, we:2'b00, a0:4'd3, a1:4'd5, d0:32'h0, d1:32'h0,
              b0:4'b0000, b1:4'b0000, ev:2'b00, e0:32'h0, e1:32'h0, e1_wf:32'h0};
    vt[3] = '{req:2'b11, we:2'b00, a0:4'd0, a1:4'd15, d0:32'h0, d1:32'h0,
              b0:4'b0000, b1:4'b0000, ev:2'b00, e0:32'h0, e1:32'h0, e1_wf:32'h0};
    vt[4] = '{req:2'b11, we:2'b01, a0:4'd7, a1:4'd7, d0:32'hDEAD_BEEF, d1:32'h0,
              b0:4'b1111, b1:4'b0000, ev:2'b11, e0:32'hA522_A544, e1:32'hA5FF_FFFF,
              e1_wf:32'hA5FF_FFFF};
    vt[5] = '{req:2'b00, we:2'b00, a0:4'd0, a1:4'd0, d0:32'h0, d1:32'h0,
              b0:4'b0000, b1:4'b0000, ev:2'b11, e0:Pat, e1:Pat, e1_wf:Pat};
    vt[6] = '{req:2'b01, we:2'b00, a0:4'd7, a1:4'd0, d0:32'h0, d1:32'h0,
              b0:4'b0000, b1:4'b0000, ev:2'b10, e0:32'h0, e1:Pat, e1_wf:32'hDEAD_BEEF};
    vt[7] = '{req:2'b00, we:2'b00, a0:4'd0, a1:4'd0, d0:32'h0, d1:32'h0,
              b0:4'b0000, b1:4'b0000, ev:2'b00, e0:32'h0, e1:32'h0, e1_wf:32'h0};
    vt[8] = '{req:2'b00, we:2'b00, a0:4'd0, a1:4'd0, d0:32'h0, d1:32'h0,
              b0:4'b0000, b1:4'b0000, ev:2'b01, e0:32'hDEAD_BEEF, e1:32'h0, e1_wf:32'h0};
    vt[9] = '{req:2'b00, we:2'b00, a0:4'd0, a1:4'd0, d0:32'h0, d1:32'h0,
              b0:4'b0000, b1:4'b0000, ev:2'b00, e0:32'h0, e1:32'h0, e1_wf:32'h0};

    // Power-on fill with requests held on both ports.
    rst  = 1'b1;
    init = 1'b0;
    drive(2'b11, 2'b00, 4'd0, 4'd15, 32'h0, 32'h0, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_rf, 1'b1);
    chk("rst_gnt", bus_rf.gnt_o, 2'b00);
    chk("rst_rvalid", bus_rf.rvalid_o, 2'b00);
    chk("rst_rdata0", bus_rf.rdata_o[0], 32'h0);
    rst = 1'b0;
    count_busy("por");
    chk("por_gnt_release", bus_rf.gnt_o, 2'b11);
    for (int c = 0; c < 18; c++) begin
      if (c >= 2) begin
        chk($sformatf("rdall%0d_rv", c - 2), bus_rf.rvalid_o, 2'b11);
        chk($sformatf("rdall%0d_d0", c - 2), bus_rf.rdata_o[0], Pat);
        chk($sformatf("rdall%0d_d1", c - 2), bus_rf.rdata_o[1], Pat);
      end
      if (c < 16) begin
        drive(2'b11, 2'b00, 4'(c), 4'(15 - c), 32'h0, 32'h0, 4'b0000, 4'b0000);
      end else begin
        drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'b0000, 4'b0000);
      end
      @(negedge clk);
    end

    // Byte-enable writes, port priority, collisions, back-to-back reads.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_rv_rf", i), bus_rf.rvalid_o, vt[i].ev);
      chk($sformatf("tbl%0d_rv_wf", i), bus_wf.rvalid_o, vt[i].ev);
      if (vt[i].ev[0]) begin
        chk($sformatf("tbl%0d_d0_rf", i), bus_rf.rdata_o[0], vt[i].e0);
        chk($sformatf("tbl%0d_d0_wf", i), bus_wf.rdata_o[0], vt[i].e0);
      end
      if (vt[i].ev[1]) begin
        chk($sformatf("tbl%0d_d1_rf", i), bus_rf.rdata_o[1], vt[i].e1);
        chk($sformatf("tbl%0d_d1_wf", i), bus_wf.rdata_o[1], vt[i].e1_wf);
      end
      drive(vt[i].req, vt[i].we, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1, vt[i].b0, vt[i].b1);
      @(negedge clk);
    end

    // init_i with two reads in flight and requests held.
    drive(2'b11, 2'b00, 4'd3, 4'd7, 32'h0, 32'h0, 4'b0000, 4'b0000);
    @(negedge clk);
    init = 1'b1;
    drive(2'b11, 2'b00, 4'd5, 4'd3, 32'h0, 32'h0, 4'b0000, 4'b0000);
    #1;
    chk("ini_gnt_idle", bus_rf.gnt_o, 2'b11);
    @(negedge clk);
    init = 1'b0;
    drive(2'b11, 2'b00, 4'd3, 4'd7, 32'h0, 32'h0, 4'b0000, 4'b0000);
    it = 0;
    while (busy_rf === 1'b1 && it < 40) begin
      chk($sformatf("ini_gnt%0d", it), bus_rf.gnt_o, 2'b00);
      if (it == 0) begin
        chk("ini_fl0_rv", bus_rf.rvalid_o, 2'b11);
        chk("ini_fl0_d0", bus_rf.rdata_o[0], 32'hA522_A544);
        chk("ini_fl0_d1", bus_rf.rdata_o[1], 32'hDEAD_BEEF);
        chk("ini_fl0_d1_wf", bus_wf.rdata_o[1], 32'hDEAD_BEEF);
      end else if (it == 1) begin
        chk("ini_fl1_rv", bus_rf.rvalid_o, 2'b11);
        chk("ini_fl1_d0", bus_rf.rdata_o[0], 32'hA5FF_FFFF);
        chk("ini_fl1_d1", bus_rf.rdata_o[1], 32'hA522_A544);
      end else begin
        chk($sformatf("ini_rv%0d", it), bus_rf.rvalid_o, 2'b00);
        if (it == 2) begin
          chk("ini_hold_d0", bus_rf.rdata_o[0], 32'hA5FF_FFFF);
          chk("ini_hold_d1", bus_rf.rdata_o[1], 32'hA522_A544);
        end
      end
      it++;
      @(negedge clk);
    end
    chk("ini_len", it, 16);
    chk("ini_gnt_release", bus_rf.gnt_o, 2'b11);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("ini_post_rv", bus_rf.rvalid_o, 2'b11);
    chk("ini_post_d0", bus_rf.rdata_o[0], Pat);
    chk("ini_post_d1", bus_rf.rdata_o[1], Pat);
    chk("ini_post_d1_wf", bus_wf.rdata_o[1], Pat);

    // Reset partway through a fill restarts it from word 0.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mid_busy%0d", k), busy_rf, 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    drive(2'b11, 2'b00, 4'd15, 4'd8, 32'h0, 32'h0, 4'b0000, 4'b0000);
    #1;
    chk("mid_rst_busy", busy_rf, 1'b1);
    chk("mid_rst_gnt", bus_rf.gnt_o, 2'b00);
    chk("mid_rst_rv", bus_rf.rvalid_o, 2'b00);
    chk("mid_rst_d0", bus_rf.rdata_o[0], 32'h0);
    chk("mid_rst_d1_wf", bus_wf.rdata_o[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_busy("mid");
    chk("mid_gnt_release", bus_rf.gnt_o, 2'b11);
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("mid_post_rv", bus_rf.rvalid_o, 2'b11);
    chk("mid_post_d0", bus_rf.rdata_o[0], Pat);
    chk("mid_post_d1", bus_rf.rdata_o[1], Pat);
    @(negedge clk);
    chk("mid_post_rv_off", bus_rf.rvalid_o, 2'b00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
